// File: rtl/uart_autobaud.sv
// Auto-baud front end for uart_rx: times a 0x55 sync character on the raw pin, programs div (bit period - 2), then forwards the line.
// Lock lands 2 cycles after the 5th falling edge is visible; no backpressure, hunt restarts the search from any state.
module uart_autobaud #(
    parameter int                   DIV_WIDTH   = 8,
    parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 8'd102,
    parameter int                   MIN_BIT     = 4,
    parameter bit                   AUTO_START  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 rx_out,
    output logic [DIV_WIDTH-1:0] div,
    input  logic                 hunt,
    output logic                 locked,
    output logic                 err_stb
);

    localparam int IW = DIV_WIDTH + 3;
    localparam int TW = DIV_WIDTH + 5;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_IDLE  = 3'd1;
    localparam logic [2:0] S_WAIT_START = 3'd2;
    localparam logic [2:0] S_MEASURE    = 3'd3;
    localparam logic [2:0] S_COMPUTE    = 3'd4;
    localparam logic [2:0] S_LOCKED     = 3'd5;

    localparam logic [2:0]  RESET_STATE = AUTO_START ? S_WAIT_IDLE : S_IDLE;
    localparam logic [TW:0] MIN_T       = (TW+1)'(MIN_BIT);
    localparam logic [TW:0] MAX_T       = (TW+1)'((1 << DIV_WIDTH) + 1);

    logic [2:0]    state;
    logic [1:0]    sync_q;
    logic          rx_s;
    logic          rx_d;
    logic          fall;
    logic [3:0]    idle_cnt;
    logic [IW-1:0] icnt;
    logic [IW-1:0] ref_iv;
    logic [TW-1:0] total;
    logic [2:0]    edge_idx;
    logic          bad;

    logic [IW-1:0] diff;
    logic          dev_bad;
    logic [TW:0]   t_sum;
    logic [TW:0]   t_val;
    logic          accept;

    assign rx_s = sync_q[1];
    assign fall = rx_d & ~rx_s;

    always_comb begin
        diff    = (icnt >= ref_iv) ? (icnt - ref_iv) : (ref_iv - icnt);
        dev_bad = diff > (ref_iv >> 3);
        // Eight bit periods span the four intervals, so /8 with +4 rounds to the nearest period.
        t_sum   = {1'b0, total} + (TW+1)'(4);
        t_val   = t_sum >> 3;
        accept  = !bad && (t_val >= MIN_T) && (t_val <= MAX_T);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RESET_STATE;
            sync_q   <= 2'b11;
            rx_d     <= 1'b1;
            rx_out   <= 1'b1;
            div      <= DEFAULT_DIV;
            locked   <= 1'b0;
            err_stb  <= 1'b0;
            idle_cnt <= '0;
            icnt     <= '0;
            ref_iv   <= '0;
            total    <= '0;
            edge_idx <= '0;
            bad      <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            rx_d    <= rx_s;
            err_stb <= 1'b0;
            rx_out  <= (locked && !hunt) ? rx_s : 1'b1;

            if (hunt) begin
                locked   <= 1'b0;
                state    <= S_WAIT_IDLE;
                idle_cnt <= '0;
                icnt     <= '0;
                total    <= '0;
                edge_idx <= '0;
                bad      <= 1'b0;
            end else begin
                case (state)
                    S_WAIT_IDLE: begin
                        // Require 16 quiet cycles so we never start timing in the middle of a frame.
                        if (!rx_s) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == 4'd15) begin
                            idle_cnt <= '0;
                            state    <= S_WAIT_START;
                        end else begin
                            idle_cnt <= idle_cnt + 4'd1;
                        end
                    end
                    S_WAIT_START: begin
                        if (fall) begin
                            icnt     <= IW'(1);
                            edge_idx <= 3'd1;
                            total    <= '0;
                            bad      <= 1'b0;
                            state    <= S_MEASURE;
                        end
                    end
                    S_MEASURE: begin
                        if (fall) begin
                            icnt     <= IW'(1);
                            edge_idx <= edge_idx + 3'd1;
                            total    <= total + {2'b00, icnt};
                            if (edge_idx == 3'd1) begin
                                ref_iv <= icnt;
                            end else if (dev_bad) begin
                                bad <= 1'b1;
                            end
                            if (edge_idx == 3'd4) begin
                                state <= S_COMPUTE;
                            end
                        end else if (icnt == {IW{1'b1}}) begin
                            err_stb  <= 1'b1;
                            state    <= S_WAIT_IDLE;
                            icnt     <= '0;
                            total    <= '0;
                            edge_idx <= '0;
                        end else begin
                            icnt <= icnt + IW'(1);
                        end
                    end
                    S_COMPUTE: begin
                        if (accept) begin
                            div    <= DIV_WIDTH'(t_val - (TW+1)'(2));
                            locked <= 1'b1;
                            state  <= S_LOCKED;
                        end else begin
                            err_stb <= 1'b1;
                            state   <= S_WAIT_IDLE;
                        end
                        icnt     <= '0;
                        total    <= '0;
                        edge_idx <= '0;
                        bad      <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: sync characters at several bit periods, error bounds, hunt and async reset.
module tb_uart_autobaud;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       hunt = 1'b0;
    logic       rx_out;
    logic [7:0] div;
    logic       locked;
    logic       err_stb;

    int checks = 0;
    int errors = 0;

    uart_autobaud #(
        .DIV_WIDTH  (8),
        .DEFAULT_DIV(8'd102),
        .MIN_BIT    (4),
        .AUTO_START (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .rx_out (rx_out),
        .div    (div),
        .hunt   (hunt),
        .locked (locked),
        .err_stb(err_stb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Idle line, then five falling edges spaced by the given intervals; returns right after driving the 5th fall.
    task automatic send_sync(input int i1, input int i2, input int i3, input int i4);
        int iv[4];
        int lo;
        iv = '{i1, i2, i3, i4};
        lo = i1 / 2;
        rx = 1'b1;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            rx = 1'b0;
            repeat (lo) @(negedge clk);
            rx = 1'b1;
            repeat (iv[k] - lo) @(negedge clk);
        end
        rx = 1'b0;
    endtask

    task automatic expect_lock(input string tag, input int div_exp);
        repeat (3) @(negedge clk);
        check({tag, "_locked_early"}, int'(locked), 0);
        @(negedge clk);
        check({tag, "_locked"}, int'(locked), 1);
        check({tag, "_div"}, int'(div), div_exp);
    endtask

    task automatic expect_err(input string tag, input int div_exp);
        repeat (3) @(negedge clk);
        check({tag, "_err_early"}, int'(err_stb), 0);
        @(negedge clk);
        check({tag, "_err"}, int'(err_stb), 1);
        @(negedge clk);
        check({tag, "_err_pulse"}, int'(err_stb), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_div"}, int'(div), div_exp);
    endtask

    task automatic pulse_hunt(input string tag, input int div_exp);
        @(negedge clk);
        hunt = 1'b1;
        @(negedge clk);
        hunt = 1'b0;
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_rx_out"}, int'(rx_out), 1);
        check({tag, "_div"}, int'(div), div_exp);
        rx = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_div", int'(div), 102);
        check("rst_locked", int'(locked), 0);
        check("rst_rx_out", int'(rx_out), 1);
        check("rst_err", int'(err_stb), 0);
        rst = 1'b0;

        // T=20: four intervals of 40, total 160.
        send_sync(40, 40, 40, 40);
        expect_lock("t20", 18);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check("fwd_before", int'(rx_out), 0);
        @(negedge clk);
        check("fwd_after", int'(rx_out), 1);

        repeat (5) @(negedge clk);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        check("fwd_low", int'(rx_out), 0);
        pulse_hunt("hunt1", 18);

        // T=21: total 168.
        send_sync(42, 42, 42, 42);
        expect_lock("t21", 19);
        pulse_hunt("hunt2", 19);

        // Stretched pair: I3 = 2*ref must be rejected.
        send_sync(20, 20, 40, 20);
        expect_err("stretch", 19);
        send_sync(20, 20, 20, 20);
        expect_lock("t10", 8);
        pulse_hunt("hunt3", 8);

        // T=20.5: total 164 rounds up to 21.
        send_sync(41, 41, 41, 41);
        expect_lock("t20p5", 19);
        pulse_hunt("hunt4", 19);

        send_sync(6, 6, 6, 6);
        expect_err("min_bit", 19);
        send_sync(600, 600, 600, 600);
        expect_err("overflow", 19);
        send_sync(514, 514, 514, 514);
        expect_lock("t257", 255);
        pulse_hunt("hunt5", 255);

        // Line stuck low after the start edge: counter saturates at 2047.
        rx = 1'b1;
        repeat (20) @(negedge clk);
        rx = 1'b0;
        repeat (2049) @(negedge clk);
        check("timeout_early", int'(err_stb), 0);
        @(negedge clk);
        check("timeout_err", int'(err_stb), 1);
        @(negedge clk);
        check("timeout_pulse", int'(err_stb), 0);
        send_sync(40, 40, 40, 40);
        expect_lock("relock", 18);
        pulse_hunt("hunt6", 18);

        // Async reset in the middle of a measurement.
        rx = 1'b1;
        repeat (20) @(negedge clk);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_div", int'(div), 102);
        check("arst_locked", int'(locked), 0);
        check("arst_rx_out", int'(rx_out), 1);
        check("arst_err", int'(err_stb), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
